// File: rtl/store_buffer.sv
// store_buffer
//   Small circular FIFO of pending stores that sits between the MEM stage and
//   the data-memory port. A store is accepted into the buffer in one cycle,
//   with no memory access in that cycle. Buffered stores are written to memory
//   in program order on cycles that do not issue a memory read.
//
//   A load is looked up in the buffer:
//   - If the youngest overlapping store covers every byte of the load, the
//     load data comes from the buffer.
//   - If the overlap is only partial, the stage stalls while the buffer drains.
//   - If nothing overlaps, the load reads memory.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   st_valid/addr/data/funct3   store request from MEM (data unshifted)
//   ld_valid/addr/funct3        load request from MEM
//   ld_data                     extended load result
//   stall                       hold MEM and everything upstream
//   empty                       no stores pending
//   mem_read/write/a/wd/funct3  data-memory request
//   mem_rd                      data-memory read data (same cycle)
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [DM_ADDRESS-1:0] st_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [2:0]            st_funct3,
  input  logic                  ld_valid,
  input  logic [DM_ADDRESS-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  stall,
  output logic                  empty,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      r_valid;
  logic [DM_ADDRESS-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0]     r_data [DEPTH];
  logic [2:0]            r_f3   [DEPTH];

  logic [3:0]            w_emask [DEPTH];
  logic [3:0]            w_ld_mask;
  logic                  w_hit;
  logic [PW-1:0]         w_hit_idx;
  logic [PW-1:0]         w_idx;
  logic                  w_cover;
  logic [DATA_W-1:0]     w_fwd_raw;
  logic [DATA_W-1:0]     w_fwd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drain_req;
  logic                  w_drain;

  function automatic logic [3:0] f_st_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  f_st_mask = 4'b0001 << off;
      3'b001:  f_st_mask = 4'b0011 << off;
      default: f_st_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] f_ld_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: f_ld_mask = 4'b0001 << off;
      3'b001, 3'b101: f_ld_mask = 4'b0011 << off;
      default:        f_ld_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  f_extend = {{(DATA_W-8){w[7]}}, w[7:0]};
      3'b001:  f_extend = {{(DATA_W-16){w[15]}}, w[15:0]};
      3'b100:  f_extend = {{(DATA_W-8){1'b0}}, w[7:0]};
      3'b101:  f_extend = {{(DATA_W-16){1'b0}}, w[15:0]};
      default: f_extend = w;
    endcase
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign empty   = w_empty;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_emask[i] = f_st_mask(r_f3[i], r_addr[i][1:0]);
    end
  end

  // The walk runs from oldest to youngest, so the last match is the youngest.
  always_comb begin
    w_ld_mask = f_ld_mask(ld_funct3, ld_addr[1:0]);
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && r_valid[w_idx] &&
          (r_addr[w_idx][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2]) &&
          ((w_emask[w_idx] & w_ld_mask) != '0)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_idx;
      end
    end
  end

  // Align the store bytes to the word, then bring the load's first byte to bit 0.
  assign w_cover   = ((w_emask[w_hit_idx] & w_ld_mask) == w_ld_mask);
  assign w_fwd_raw = (r_data[w_hit_idx] << {r_addr[w_hit_idx][1:0], 3'b000})
                     >> {ld_addr[1:0], 3'b000};
  assign w_fwd     = f_extend(w_fwd_raw, ld_funct3);

  always_comb begin
    stall       = 1'b0;
    mem_read    = 1'b0;
    w_push      = 1'b0;
    w_drain_req = 1'b0;
    ld_data     = mem_rd;
    if (ld_valid) begin
      if (!w_hit) begin
        mem_read = 1'b1;
      end else if (w_cover) begin
        ld_data     = w_fwd;
        w_drain_req = 1'b1;
      end else begin
        stall       = 1'b1;
        w_drain_req = 1'b1;
      end
    end else if (st_valid) begin
      if (w_full) begin
        stall       = 1'b1;
        w_drain_req = 1'b1;
      end else begin
        w_push = 1'b1;
      end
    end else begin
      w_drain_req = 1'b1;
    end
  end

  assign w_drain    = w_drain_req && !w_empty;
  assign mem_write  = w_drain;
  assign mem_a      = mem_read ? ld_addr : r_addr[r_head];
  assign mem_funct3 = mem_read ? ld_funct3 : r_f3[r_head];
  assign mem_wd     = r_data[r_head];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= st_addr;
        r_data[r_tail]  <= st_data;
        r_f3[r_tail]    <= st_funct3;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 9;
  localparam logic [31:0] R = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_funct3;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic [31:0]   ld_data;
  logic          stall;
  logic          empty;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_rd;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_data(ld_data), .stall(stall), .empty(empty),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: list of pending stores, byte ranges ----
  typedef struct { logic [AW-1:0] a; logic [31:0] d; logic [2:0] f; } st_t;
  st_t q[$];

  function automatic int st_size(input logic [2:0] f);
    if (f == 3'b000) return 1;
    if (f == 3'b001) return 2;
    return 4;
  endfunction

  function automatic int ld_size(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int base_of(input logic [AW-1:0] a, input int sz);
    if (sz == 4) return int'(a) & ~3;
    return int'(a);
  endfunction

  // Checks the current DUT outputs against the model, then advances the model
  // as the clock edge will. Returns whether the request must be held.
  task automatic model_step(output logic held);
    int found = -1;
    int lsz, lb, ssz, sb, b;
    logic partial = 1'b0;
    logic e_rd = 1'b0, e_stall = 1'b0, e_drain = 1'b0, e_push = 1'b0;
    logic [31:0] e_ld, byt;
    e_ld = mem_rd;
    if (ld_valid) begin
      lsz = ld_size(ld_funct3);
      lb  = base_of(ld_addr, lsz);
      for (int i = int'(q.size()) - 1; i >= 0 && found < 0; i--) begin
        ssz = st_size(q[i].f);
        sb  = base_of(q[i].a, ssz);
        if (lb < sb + ssz && sb < lb + lsz) found = i;
      end
      if (found < 0) begin
        e_rd = 1'b1;
      end else begin
        ssz = st_size(q[found].f);
        sb  = base_of(q[found].a, ssz);
        e_drain = 1'b1;
        if (sb <= lb && lb + lsz <= sb + ssz) begin
          e_ld = '0;
          for (int k = 0; k < lsz; k++) begin
            b   = lb + k;
            byt = (q[found].d >> (8 * (b - sb))) & 32'hFF;
            e_ld = e_ld | (byt << (8 * k));
          end
          if (ld_funct3 == 3'b000 && e_ld[7])  e_ld = e_ld | 32'hFFFF_FF00;
          if (ld_funct3 == 3'b001 && e_ld[15]) e_ld = e_ld | 32'hFFFF_0000;
        end else begin
          partial = 1'b1;
          e_stall = 1'b1;
        end
      end
    end else if (st_valid) begin
      if (q.size() == DEPTH) begin
        e_stall = 1'b1;
        e_drain = 1'b1;
      end else begin
        e_push = 1'b1;
      end
    end else begin
      e_drain = (q.size() > 0);
    end

    chk("m_stall", 32'(stall), 32'(e_stall));
    chk("m_mem_read", 32'(mem_read), 32'(e_rd));
    chk("m_mem_write", 32'(mem_write), 32'(e_drain));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    if (!partial) chk("m_ld_data", ld_data, e_ld);
    if (e_rd) begin
      chk("m_rd_addr", 32'(mem_a), 32'(ld_addr));
      chk("m_rd_f3", 32'(mem_funct3), 32'(ld_funct3));
    end
    if (e_drain) begin
      chk("m_wr_addr", 32'(mem_a), 32'(q[0].a));
      chk("m_wr_data", mem_wd, q[0].d);
      chk("m_wr_f3", 32'(mem_funct3), 32'(q[0].f));
      void'(q.pop_front());
    end
    if (e_push) q.push_back('{st_addr, st_data, st_funct3});
    held = e_stall;
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic sv; logic [AW-1:0] sa; logic [31:0] sd; logic [2:0] sf;
    logic lv; logic [AW-1:0] la; logic [2:0] lf; logic [31:0] rd;
    logic e_stall, e_rd, e_wr; logic [AW-1:0] e_a; logic [31:0] e_wd;
    logic chk_ld; logic [31:0] e_ld; logic e_empty;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic sv, input logic [AW-1:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                     input logic lv, input logic [AW-1:0] la, input logic [2:0] lf, input logic [31:0] rd,
                     input logic es, input logic er, input logic ew, input logic [AW-1:0] ea,
                     input logic [31:0] ewd, input logic cl, input logic [31:0] eld, input logic eem);
    tbl.push_back('{sv, sa, sd, sf, lv, la, lf, rd, es, er, ew, ea, ewd, cl, eld, eem});
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f,
                    input logic es, input logic ew, input logic [AW-1:0] ea, input logic [31:0] ewd,
                    input logic eem);
    add(1, a, d, f, 0, '0, 3'd0, R, es, 0, ew, ea, ewd, 1, R, eem);
  endtask

  task automatic idle(input logic ew, input logic [AW-1:0] ea, input logic [31:0] ewd, input logic eem);
    add(0, '0, '0, 3'd0, 0, '0, 3'd0, R, 0, 0, ew, ea, ewd, 1, R, eem);
  endtask

  task automatic drive_idle();
    st_valid = 0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 0; ld_addr = '0; ld_funct3 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  logic held;
  logic [AW-1:0] ra;
  logic [2:0] rf;
  int kind, sz;

  initial begin
    reset = 1'b0;
    mem_rd = R;
    drive_idle();
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_ld_data", ld_data, R);
    @(posedge clk); #1;

    // single store, drain on idle
    st(9'h010, 32'hDEADBEEF, 3'd2, 0, 0, '0, '0, 1);
    idle(1, 9'h010, 32'hDEADBEEF, 0);
    idle(0, '0, '0, 1);
    // five back-to-back SWs
    st(9'h100, 32'h11, 3'd2, 0, 0, '0, '0, 1);
    st(9'h104, 32'h22, 3'd2, 0, 0, '0, '0, 0);
    st(9'h108, 32'h33, 3'd2, 0, 0, '0, '0, 0);
    st(9'h10C, 32'h44, 3'd2, 0, 0, '0, '0, 0);
    st(9'h110, 32'h55, 3'd2, 1, 1, 9'h100, 32'h11, 0);
    st(9'h110, 32'h55, 3'd2, 0, 0, '0, '0, 0);
    idle(1, 9'h104, 32'h22, 0);
    idle(1, 9'h108, 32'h33, 0);
    idle(1, 9'h10C, 32'h44, 0);
    idle(1, 9'h110, 32'h55, 0);
    idle(0, '0, '0, 1);
    // forwarding with extension; each forwarded load drains its store
    st(9'h020, 32'h12345678, 3'd2, 0, 0, '0, '0, 1);
    add(0, '0, '0, 0, 1, 9'h023, 3'd0, R, 0, 0, 1, 9'h020, 32'h12345678, 1, 32'h12, 0);
    st(9'h020, 32'h12345678, 3'd2, 0, 0, '0, '0, 1);
    add(0, '0, '0, 0, 1, 9'h022, 3'd1, R, 0, 0, 1, 9'h020, 32'h12345678, 1, 32'h1234, 0);
    st(9'h020, 32'h12345678, 3'd2, 0, 0, '0, '0, 1);
    add(0, '0, '0, 0, 1, 9'h020, 3'd4, R, 0, 0, 1, 9'h020, 32'h12345678, 1, 32'h78, 0);
    // partial overlap stalls, then reads memory
    st(9'h031, 32'h80, 3'd0, 0, 0, '0, '0, 1);
    add(0, '0, '0, 0, 1, 9'h030, 3'd2, R, 1, 0, 1, 9'h031, 32'h80, 0, '0, 0);
    add(0, '0, '0, 0, 1, 9'h030, 3'd2, 32'hCAFEF00D, 0, 1, 0, 9'h030, '0, 1, 32'hCAFEF00D, 1);
    // signed byte forward
    st(9'h031, 32'h80, 3'd0, 0, 0, '0, '0, 1);
    add(0, '0, '0, 0, 1, 9'h031, 3'd0, R, 0, 0, 1, 9'h031, 32'h80, 1, 32'hFFFFFF80, 0);
    // youngest match wins
    st(9'h040, 32'h1, 3'd2, 0, 0, '0, '0, 1);
    st(9'h040, 32'h2, 3'd2, 0, 0, '0, '0, 0);
    add(0, '0, '0, 0, 1, 9'h040, 3'd2, R, 0, 0, 1, 9'h040, 32'h1, 1, 32'h2, 0);
    idle(1, 9'h040, 32'h2, 0);
    idle(0, '0, '0, 1);

    foreach (tbl[i]) begin
      st_valid = tbl[i].sv; st_addr = tbl[i].sa; st_data = tbl[i].sd; st_funct3 = tbl[i].sf;
      ld_valid = tbl[i].lv; ld_addr = tbl[i].la; ld_funct3 = tbl[i].lf; mem_rd = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      if (tbl[i].e_wr || tbl[i].e_rd) chk($sformatf("v%0d_mem_a", i), 32'(mem_a), 32'(tbl[i].e_a));
      if (tbl[i].e_wr) chk($sformatf("v%0d_mem_wd", i), mem_wd, tbl[i].e_wd);
      if (tbl[i].chk_ld) chk($sformatf("v%0d_ld_data", i), ld_data, tbl[i].e_ld);
      model_step(held);
      @(posedge clk); #1;
    end

    // reset with three stores pending discards them
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = AW'(9'h060 + 4 * i); st_data = 32'h600 + i; st_funct3 = 3'd2;
      @(negedge clk);
      model_step(held);
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    chk("rst2_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst2_no_write", 32'(mem_write), 32'd0);
      model_step(held);
      @(posedge clk); #1;
    end

    // randomized traffic against the model
    held = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!held && $urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      mem_rd = $urandom;
      if (!held) begin
        drive_idle();
        kind = $urandom_range(0, 9);
        ra = AW'(9'h140 + 4 * $urandom_range(0, 3));
        if (kind < 5) begin
          rf = 3'($urandom_range(0, 3));
          sz = st_size(rf);
          if (sz == 1) ra = ra + AW'($urandom_range(0, 3));
          else if (sz == 2) ra = ra + AW'(2 * $urandom_range(0, 1));
          st_valid = 1; st_addr = ra; st_data = $urandom; st_funct3 = rf;
        end else if (kind < 8) begin
          case ($urandom_range(0, 5))
            0: rf = 3'b000; 1: rf = 3'b001; 2: rf = 3'b010;
            3: rf = 3'b100; 4: rf = 3'b101; default: rf = 3'b110;
          endcase
          sz = ld_size(rf);
          if (sz == 1) ra = ra + AW'($urandom_range(0, 3));
          else if (sz == 2) ra = ra + AW'(2 * $urandom_range(0, 1));
          ld_valid = 1; ld_addr = ra; ld_funct3 = rf;
        end
      end
      @(negedge clk);
      model_step(held);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small FIFO of pending stores between the MEM pipeline stage and the data memory port; it drives the memory's MemRead/MemWrite/a/wd/Funct3 inputs and receives its rd output.
- Stores retire into the buffer in one cycle and drain to memory on idle cycles, so store bursts do not occupy the memory port.
- Loads are checked against the buffer: full byte coverage is forwarded, partial overlap stalls until the conflicting store has drained.

Parameters:
DEPTH, 4, number of buffered stores (power of two, >=2)
DM_ADDRESS, 9, byte-address width forwarded to data memory
DATA_W, 32, data width (only 32 is supported)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
st_valid  input  1  MEM stage holds a store this cycle
st_addr  input  DM_ADDRESS  store byte address
st_data  input  DATA_W  store data, unshifted (value in low bits)
st_funct3  input  3  000 SB, 001 SH, 010 SW; others treated as SW
ld_valid  input  1  MEM stage holds a load this cycle (never together with st_valid)
ld_addr  input  DM_ADDRESS  load byte address
ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
ld_data  output  DATA_W  load result, already extended
stall  output  1  hold MEM stage and everything upstream
empty  output  1  buffer holds no stores
mem_read  output  1  to data memory MemRead
mem_write  output  1  to data memory MemWrite
mem_a  output  DM_ADDRESS  to data memory a
mem_wd  output  DATA_W  to data memory wd
mem_funct3  output  3  to data memory Funct3
mem_rd  input  DATA_W  from data memory rd, same-cycle read

Behaviour:
- Storage: circular FIFO; head pointer, tail pointer and a count of 0..DEPTH. Each entry holds addr, data and funct3.
- Byte mask: SB = 1 << addr[1:0]; SH = 0011 << addr[1:0]; SW = 1111. Word match compares addr[DM_ADDRESS-1:2].
- Reset: count, head and tail = 0; entries invalid; empty=1. All outputs are combinational and with no request active are stall=0, mem_read=0, mem_write=0, ld_data=mem_rd.
- Reset mid-operation discards pending stores; this is intended.
- Push: when st_valid and count<DEPTH, the entry is written at the tail on the rising edge and tail and count advance. No memory access happens that cycle. stall=0.
- Full: when st_valid and count==DEPTH, stall=1 and the head drains that cycle. The held store pushes the next cycle with stall=0, so full costs exactly one stall cycle.
- Load lookup (combinational): find the youngest valid entry whose word matches and whose mask ANDed with the load mask is nonzero.
  - No entry found: mem_read=1, mem_a=ld_addr, mem_funct3=ld_funct3, ld_data=mem_rd, no drain.
  - Found and entry mask covers the load mask: ld_data = extend((entry data << 8*entry addr[1:0]) >> 8*ld_addr[1:0], ld_funct3). mem_read=0 and the head drains this cycle.
  - Found but coverage is partial: stall=1 and the head drains; this repeats each cycle until the lookup resolves to one of the cases above.
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Drain: when no memory read is issued and count>0 (idle cycle, full stall, or forwarded/conflict load), mem_write=1 and mem_a/mem_wd/mem_funct3 come from the head entry. Head and count update on the edge.
- Simultaneous: a drain and a push in the same cycle leave count unchanged. A drain never overlaps a memory read.
- Ordering: memory writes occur strictly in program order. Stores and loads are never reordered in memory-visible effect.
- empty = (count==0). Software or a fence can poll it.
- Misaligned SH/LH (addr[0]=1) is undefined; no checking is done.

Test Plan:
- After reset, SW 0xDEADBEEF to 0x010, then one idle cycle -> push with mem_write=0; next cycle mem_write=1, mem_a=0x010, mem_wd=0xDEADBEEF, empty=1 afterwards.
- 5 back-to-back SWs with DEPTH=4 -> the 5th cycle has stall=1 and a drain of the first store. The next cycle accepts the 5th store with stall=0. Drain order matches issue order on 4 idle cycles.
- SW 0x12345678 to 0x020 then LB 0x023 -> ld_data=0x00000012 forwarded, mem_read=0, no stall. LH 0x022 -> 0x00001234. LBU 0x020 -> 0x00000078.
- SB 0x80 to 0x031 then LW 0x030 -> stall=1 while the SB drains, then mem_read=1 and ld_data=mem_rd. LB 0x031 right after the SB -> 0xFFFFFF80 forwarded.
- Two SWs to 0x040 (0x1, then 0x2) then LW 0x040 -> the youngest is forwarded, ld_data=0x00000002.
- Reset asserted with 3 entries pending -> empty=1 next cycle and no mem_write is ever issued for the discarded entries.
